scoring_graded: RTL and testbench
=================================

Name: scoring_graded

Overview:
- Parametrised successor to the single-window hit/no-hit scorer.
- Judges each beat per lane with timing grades: PERFECT, GOOD or MISS.
- Keeps a saturating score with a combo multiplier, plus current and best combo.
- Sits between the step sequencer (step, beat_en, window_close) and the display/LED drivers. Player buttons are raw levels.

Parameters:
- LANES, 4, number of arrow lanes.
- SCORE_W, 16, score width; saturates at all-ones.
- COMBO_W, 8, combo and max_combo width; saturating.
- TIME_W, 24, width of the since-beat timer; saturates at all-ones.
- PERFECT_WIN, 2500000, max cycles after beat_en for a PERFECT press.
- GOOD_WIN, 7500000, max cycles after beat_en for a GOOD press. Must be >= PERFECT_WIN.
- PERFECT_PTS, 2, base points for PERFECT.
- GOOD_PTS, 1, base points for GOOD.
- COMBO_THRESH, 10, combo at or above which points are doubled.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low (reset==0 clears all state on the clk edge).
- step  in  LANES  required lanes for the current beat; sampled on beat_en only.
- beat_en  in  1  one-cycle pulse marking the target instant of a step; opens the judgement window.
- window_close  in  1  one-cycle pulse ending the judgement window (half-beat point).
- button  in  LANES  raw button levels, already synchronised.
- score  out  SCORE_W  accumulated score.
- combo  out  COMBO_W  consecutive non-MISS judgements.
- max_combo  out  COMBO_W  highest combo since reset.
- judge_valid  out  1  one-cycle pulse when a judgement is issued.
- judge  out  2  grade: 00 none, 01 MISS, 10 GOOD, 11 PERFECT; holds its last value.
- green_led  out  1  last judgement was GOOD or PERFECT.
- red_led  out  1  last judgement was MISS.

Behaviour:
- Reset values: all outputs 0; state IDLE; timer 0; all lane flags 0. Edge-detector history loads the current button value, so a button held through reset does not count as a press.
- Edge detect: press[i] = button[i] & ~prev[i]; prev updates every cycle.
- FSM states: IDLE, OPEN, JUDGE.
- IDLE:
  - beat_en -> OPEN. step_q <= step; timer <= 0; hit, wrong and late flags cleared.
  - Presses are ignored.
  - window_close alone is ignored.
  - beat_en and window_close in the same cycle: beat_en wins.
- OPEN:
  - Timer increments every cycle, saturating at 2^TIME_W-1.
  - First press on lane i with step_q[i]=1: hit[i] <= 1. If timer > GOOD_WIN, late_miss <= 1. Else if timer > PERFECT_WIN, good_only <= 1.
  - Further presses on an already-hit lane are ignored.
  - Press on lane i with step_q[i]=0: wrong <= 1.
  - window_close -> JUDGE. Presses in that same cycle are still captured.
  - beat_en while OPEN is ignored. This includes beat_en together with window_close.
- JUDGE (exactly one cycle):
  - Presses are ignored.
  - If step_q==0: no judgement; no outputs change.
  - Else grade = MISS if (hit != step_q) | wrong | late_miss; else GOOD if good_only; else PERFECT.
  - Next state IDLE.
- Output update: registered at the edge ending JUDGE. window_close sampled at edge N gives judge_valid high during cycle N+2, for one cycle. Score, combo, judge and LEDs change at that same edge.
- Score:
  - pts = base << (combo_before >= COMBO_THRESH), where combo_before is combo prior to this update.
  - score <= min(score + pts, 2^SCORE_W-1), computed at SCORE_W+2 bits.
  - MISS adds 0.
- Combo:
  - GOOD/PERFECT: combo <= sat(combo+1).
  - MISS: combo <= 0.
  - max_combo <= max(max_combo, new combo).
- LEDs:
  - GOOD/PERFECT sets green_led=1, red_led=0.
  - MISS sets red_led=1, green_led=0.
  - beat_en in IDLE clears both LEDs in the same edge as opening the window.
- Reset mid-window: everything returns to reset values at that edge. No judgement is issued.

Test Plan:
(All tests override PERFECT_WIN=4, GOOD_WIN=10, COMBO_THRESH=3; other parameters at default.)
- step=0101, beat_en, press lanes 0 and 2 at timer 2 and 3, window_close -> judge=11 two cycles after close; score=2; combo=1; green_led=1.
- step=0001, press lane 0 at timer 7 -> judge=10, score+1. Press at timer 12 instead -> judge=01, combo=0, red_led=1, score unchanged.
- step=0011, press lanes 0 and 2 (extra lane 2, lane 1 missing) -> MISS. Then step=0001 with an early press before beat_en and no press in OPEN -> MISS.
- Four consecutive PERFECTs from score 0 -> score sequence 2, 4, 6, 10 (doubled once combo_before=3); max_combo=4. Then a MISS -> combo=0, max_combo stays 4.
- Score preset near max (SCORE_W=4, score 14) plus PERFECT -> score=15 (saturated). step=0000 beat -> no judge_valid, outputs unchanged.
- Reset low while OPEN with lanes hit -> all outputs 0 next cycle, no judge_valid. Button held through reset -> no press counted.

Source files
------------

// File: rtl/scoring_graded.sv
// Graded beat scorer: judges each step per lane as PERFECT/GOOD/MISS and keeps
// a saturating score with a combo multiplier, plus current and best combo.
module scoring_graded #(
    parameter int unsigned LANES        = 4,
    parameter int unsigned SCORE_W      = 16,
    parameter int unsigned COMBO_W      = 8,
    parameter int unsigned TIME_W       = 24,
    parameter int unsigned PERFECT_WIN  = 2500000,
    parameter int unsigned GOOD_WIN     = 7500000,
    parameter int unsigned PERFECT_PTS  = 2,
    parameter int unsigned GOOD_PTS     = 1,
    parameter int unsigned COMBO_THRESH = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [LANES-1:0]   step,
    input  logic               beat_en,
    input  logic               window_close,
    input  logic [LANES-1:0]   button,
    output logic [SCORE_W-1:0] score,
    output logic [COMBO_W-1:0] combo,
    output logic [COMBO_W-1:0] max_combo,
    output logic               judge_valid,
    output logic [1:0]         judge,
    output logic               green_led,
    output logic               red_led
);

    localparam int unsigned SW2 = SCORE_W + 2;
    localparam logic [TIME_W-1:0]  L_PERF_WIN = TIME_W'(PERFECT_WIN);
    localparam logic [TIME_W-1:0]  L_GOOD_WIN = TIME_W'(GOOD_WIN);
    localparam logic [COMBO_W-1:0] L_THRESH   = COMBO_W'(COMBO_THRESH);
    localparam logic [SW2-1:0]     L_SCORE_MAX = {2'b00, {SCORE_W{1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OPEN  = 2'd1,
        S_JUDGE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_open;
    logic               w_fire;

    logic [LANES-1:0]   r_prev;
    logic [LANES-1:0]   w_press;
    logic [LANES-1:0]   w_first;

    logic [LANES-1:0]   r_step_q;
    logic [LANES-1:0]   r_hit;
    logic               r_wrong;
    logic               r_late;
    logic               r_good_only;
    logic [TIME_W-1:0]  r_timer;

    logic               w_miss;
    logic [1:0]         w_grade;
    logic [SW2-1:0]     w_pts;
    logic [SW2-1:0]     w_sum;
    logic [SCORE_W-1:0] w_score_nxt;
    logic [COMBO_W-1:0] w_combo_nxt;
    logic [COMBO_W-1:0] w_max_nxt;

    logic [SCORE_W-1:0] r_score;
    logic [COMBO_W-1:0] r_combo;
    logic [COMBO_W-1:0] r_max_combo;
    logic               r_valid;
    logic [1:0]         r_judge;
    logic               r_green;
    logic               r_red;

    assign w_press = button & ~r_prev;
    assign w_first = w_press & r_step_q & ~r_hit;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state plus window-open and judgement strobes
    always_comb begin
        w_state_nxt = r_state;
        w_open      = 1'b0;
        w_fire      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (beat_en) begin
                    w_state_nxt = S_OPEN;
                    w_open      = 1'b1;
                end
            end
            S_OPEN: begin
                if (window_close) w_state_nxt = S_JUDGE;
            end
            S_JUDGE: begin
                w_state_nxt = S_IDLE;
                w_fire      = |r_step_q;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Button history; reset loads the live level so a held button is not a press
    always_ff @(posedge clk) begin
        r_prev <= button;
    end

    // Window capture: timer and per-lane hit/wrong/timing flags
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_step_q    <= '0;
            r_hit       <= '0;
            r_wrong     <= 1'b0;
            r_late      <= 1'b0;
            r_good_only <= 1'b0;
            r_timer     <= '0;
        end else if (w_open) begin
            r_step_q    <= step;
            r_hit       <= '0;
            r_wrong     <= 1'b0;
            r_late      <= 1'b0;
            r_good_only <= 1'b0;
            r_timer     <= '0;
        end else if (r_state == S_OPEN) begin
            if (r_timer != '1) r_timer <= r_timer + TIME_W'(1);
            if (|w_first) begin
                r_hit <= r_hit | w_first;
                if (r_timer > L_GOOD_WIN)      r_late      <= 1'b1;
                else if (r_timer > L_PERF_WIN) r_good_only <= 1'b1;
            end
            if (|(w_press & ~r_step_q)) r_wrong <= 1'b1;
        end
    end

    // Grade, points with combo doubling, and saturating next score/combo
    always_comb begin
        w_miss      = (r_hit != r_step_q) | r_wrong | r_late;
        w_grade     = 2'b11;
        w_pts       = SW2'(PERFECT_PTS);
        w_sum       = '0;
        w_score_nxt = r_score;
        w_combo_nxt = r_combo;
        w_max_nxt   = r_max_combo;
        if (w_miss) begin
            w_grade = 2'b01;
            w_pts   = '0;
        end else if (r_good_only) begin
            w_grade = 2'b10;
            w_pts   = SW2'(GOOD_PTS);
        end
        if (r_combo >= L_THRESH) w_pts = w_pts << 1;
        w_sum       = {2'b00, r_score} + w_pts;
        w_score_nxt = (w_sum > L_SCORE_MAX) ? {SCORE_W{1'b1}} : w_sum[SCORE_W-1:0];
        if (w_miss)              w_combo_nxt = '0;
        else if (r_combo != '1)  w_combo_nxt = r_combo + COMBO_W'(1);
        w_max_nxt = (w_combo_nxt > r_max_combo) ? w_combo_nxt : r_max_combo;
    end

    // Registered outputs: update on the edge ending JUDGE; LEDs clear on window open
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_score     <= '0;
            r_combo     <= '0;
            r_max_combo <= '0;
            r_valid     <= 1'b0;
            r_judge     <= 2'b00;
            r_green     <= 1'b0;
            r_red       <= 1'b0;
        end else begin
            r_valid <= w_fire;
            if (w_fire) begin
                r_score     <= w_score_nxt;
                r_combo     <= w_combo_nxt;
                r_max_combo <= w_max_nxt;
                r_judge     <= w_grade;
                r_green     <= ~w_miss;
                r_red       <= w_miss;
            end else if (w_open) begin
                r_green <= 1'b0;
                r_red   <= 1'b0;
            end
        end
    end

    assign score       = r_score;
    assign combo       = r_combo;
    assign max_combo   = r_max_combo;
    assign judge_valid = r_valid;
    assign judge       = r_judge;
    assign green_led   = r_green;
    assign red_led     = r_red;

endmodule

// File: tb/tb_scoring_graded.sv
// Bench for scoring_graded: directed scenarios plus randomized beats, checked
// against a per-window model built from press times and the grading rules.
module tb_scoring_graded;

    localparam int PW = 4;
    localparam int GW = 10;
    localparam int CT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  step;
    logic        beat_en;
    logic        window_close;
    logic [3:0]  button;

    logic [15:0] score;
    logic [7:0]  combo, max_combo;
    logic        judge_valid, green_led, red_led;
    logic [1:0]  judge;

    logic [3:0]  score4;
    logic [7:0]  combo4, max4;
    logic        valid4, green4, red4;
    logic [1:0]  judge4;

    int          n_chk, n_pass;
    int          m_s16, m_s4, m_combo, m_max, m_judge;
    bit          m_green, m_red;
    int          p1[4], p2[4];
    logic [3:0]  hold;

    always #5 clk = ~clk;

    scoring_graded #(.PERFECT_WIN(PW), .GOOD_WIN(GW), .COMBO_THRESH(CT)) u_dut (
        .clk(clk), .reset(reset), .step(step), .beat_en(beat_en),
        .window_close(window_close), .button(button), .score(score),
        .combo(combo), .max_combo(max_combo), .judge_valid(judge_valid),
        .judge(judge), .green_led(green_led), .red_led(red_led)
    );

    scoring_graded #(.SCORE_W(4), .PERFECT_WIN(PW), .GOOD_WIN(GW), .COMBO_THRESH(CT)) u_dut4 (
        .clk(clk), .reset(reset), .step(step), .beat_en(beat_en),
        .window_close(window_close), .button(button), .score(score4),
        .combo(combo4), .max_combo(max4), .judge_valid(valid4),
        .judge(judge4), .green_led(green4), .red_led(red4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic check_all(input string tag, input bit exp_valid);
        chk({tag, ".valid"},  32'(judge_valid), 32'(exp_valid));
        chk({tag, ".judge"},  32'(judge),       32'(m_judge));
        chk({tag, ".score"},  32'(score),       32'(m_s16));
        chk({tag, ".combo"},  32'(combo),       32'(m_combo));
        chk({tag, ".max"},    32'(max_combo),   32'(m_max));
        chk({tag, ".green"},  32'(green_led),   32'(m_green));
        chk({tag, ".red"},    32'(red_led),     32'(m_red));
        chk({tag, ".valid4"}, 32'(valid4),      32'(exp_valid));
        chk({tag, ".score4"}, 32'(score4),      32'(m_s4));
        chk({tag, ".combo4"}, 32'(combo4),      32'(m_combo));
        chk({tag, ".max4"},   32'(max4),        32'(m_max));
        chk({tag, ".judge4"}, 32'(judge4),      32'(m_judge));
    endtask

    task automatic model_reset();
        m_s16 = 0; m_s4 = 0; m_combo = 0; m_max = 0; m_judge = 0;
        m_green = 0; m_red = 0;
    endtask

    task automatic clr();
        for (int i = 0; i < 4; i++) begin
            p1[i] = -1;
            p2[i] = -1;
        end
    endtask

    // Grade one window from the first press time on each lane.
    task automatic model_update(input logic [3:0] st);
        bit miss = 0;
        bit good = 0;
        int pts;
        if (st == 4'd0) return;
        for (int i = 0; i < 4; i++) begin
            if (st[i]) begin
                if (p1[i] < 0 || p1[i] > GW) miss = 1;
                else if (p1[i] > PW)         good = 1;
            end else if (p1[i] >= 0) begin
                miss = 1;
            end
        end
        pts = miss ? 0 : (good ? 1 : 2);
        if (m_combo >= CT) pts = pts * 2;
        m_s16   = (m_s16 + pts > 65535) ? 65535 : m_s16 + pts;
        m_s4    = (m_s4 + pts > 15) ? 15 : m_s4 + pts;
        m_combo = miss ? 0 : ((m_combo == 255) ? 255 : m_combo + 1);
        if (m_combo > m_max) m_max = m_combo;
        m_judge = miss ? 1 : (good ? 2 : 3);
        m_green = !miss;
        m_red   = miss;
    endtask

    task automatic run_beat(input logic [3:0] st, input int close, input logic [3:0] pre,
                            input bit bc_same, input int extra_be, input logic [3:0] jpress);
        // Idle cycles: early presses and a lone window_close must be ignored
        @(negedge clk);
        step = 4'($urandom); beat_en = 1'b0; button = hold | pre;
        window_close = ($urandom_range(0, 3) == 0);
        chk("idle.valid",  32'(judge_valid), 32'd0);
        chk("idle.valid4", 32'(valid4),      32'd0);
        @(negedge clk);
        button = hold; window_close = 1'b0;
        // Beat: opens the window and clears LEDs
        @(negedge clk);
        step = st; beat_en = 1'b1; window_close = bc_same; button = hold;
        m_green = 0; m_red = 0;
        for (int t = 0; t <= close; t++) begin
            @(negedge clk);
            if (t == 0) begin
                chk("open.green", 32'(green_led), 32'd0);
                chk("open.red",   32'(red_led),   32'd0);
            end
            step = 4'($urandom);
            beat_en = (t == extra_be);
            window_close = (t == close);
            for (int i = 0; i < 4; i++)
                button[i] = hold[i] | (p1[i] == t) | (p2[i] == t);
        end
        // Judge cycle: presses ignored, no pulse yet
        @(negedge clk);
        beat_en = 1'b0; window_close = 1'b0; button = hold | jpress;
        chk("judgecyc.valid", 32'(judge_valid), 32'd0);
        @(negedge clk);
        button = hold;
        model_update(st);
        check_all("beat", st != 4'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; beat_en = 1'b0; window_close = 1'b0; button = hold;
        @(negedge clk);
        model_reset();
        check_all("reset", 1'b0);
        reset = 1'b1;
    endtask

    task automatic gen_window(output logic [3:0] st, output int close);
        st = 4'($urandom);
        close = $urandom_range(3, 14);
        for (int i = 0; i < 4; i++) begin
            int r;
            p1[i] = -1; p2[i] = -1;
            r = $urandom_range(0, 19);
            if (st[i]) begin
                if (r < 13)      p1[i] = $urandom_range(0, (close < PW) ? close : PW);
                else if (r < 18) p1[i] = $urandom_range(0, close);
            end else if (r == 0) begin
                p1[i] = $urandom_range(0, close);
            end
            if (p1[i] >= 0 && p1[i] + 2 <= close && $urandom_range(0, 3) == 0)
                p2[i] = $urandom_range(p1[i] + 2, close);
        end
    endtask

    int exp16[6] = '{2, 4, 6, 10, 14, 18};
    int exp4[6]  = '{2, 4, 6, 10, 14, 15};

    initial begin
        logic [3:0] st;
        int         close;
        n_chk = 0; n_pass = 0; hold = 4'd0;
        reset = 1'b0; step = 4'd0; beat_en = 1'b0; window_close = 1'b0; button = 4'd0;
        repeat (3) @(negedge clk);
        model_reset();
        check_all("por", 1'b0);
        reset = 1'b1;

        // PERFECT on two lanes
        clr(); p1[0] = 2; p1[2] = 3;
        run_beat(4'b0101, 5, 4'd0, 1'b0, -1, 4'd0);
        chk("d1.judge", 32'(judge), 32'd3);
        chk("d1.score", 32'(score), 32'd2);
        chk("d1.green", 32'(green_led), 32'd1);
        // GOOD at timer 7
        clr(); p1[0] = 7;
        run_beat(4'b0001, 9, 4'd0, 1'b0, -1, 4'd0);
        chk("d2.judge", 32'(judge), 32'd2);
        chk("d2.score", 32'(score), 32'd3);
        // Late press at timer 12
        clr(); p1[0] = 12;
        run_beat(4'b0001, 13, 4'd0, 1'b0, -1, 4'd0);
        chk("d3.judge", 32'(judge), 32'd1);
        chk("d3.red",   32'(red_led), 32'd1);
        chk("d3.score", 32'(score), 32'd3);
        // Wrong lane plus missing lane
        clr(); p1[0] = 1; p1[2] = 1;
        run_beat(4'b0011, 4, 4'd0, 1'b0, -1, 4'd0);
        chk("d4.judge", 32'(judge), 32'd1);
        // Early press in IDLE only, with beat_en+window_close together at open
        clr();
        run_beat(4'b0001, 4, 4'b0001, 1'b1, -1, 4'b0001);
        chk("d5.judge", 32'(judge), 32'd1);

        // Combo doubling and SCORE_W=4 saturation, from a clean reset
        do_reset();
        for (int k = 0; k < 6; k++) begin
            clr(); p1[0] = $urandom_range(0, PW);
            run_beat(4'b0001, 6, 4'd0, 1'b0, (k == 2) ? 3 : -1, 4'd0);
            chk("seq.score",  32'(score),  32'(exp16[k]));
            chk("seq.score4", 32'(score4), 32'(exp4[k]));
        end
        clr();
        run_beat(4'b0010, 5, 4'd0, 1'b0, 5, 4'd0);
        chk("seqmiss.combo", 32'(combo), 32'd0);
        chk("seqmiss.max",   32'(max_combo), 32'd6);
        // Empty step: no judgement
        clr(); p1[1] = 2;
        run_beat(4'b0000, 4, 4'd0, 1'b0, -1, 4'd0);

        // Reset mid-window with lanes hit; lane 0 held through reset
        @(negedge clk);
        step = 4'b0101; beat_en = 1'b1; button = 4'd0;
        @(negedge clk); beat_en = 1'b0; button = 4'b0101;
        @(negedge clk); button = 4'd0;
        @(negedge clk); reset = 1'b0; button = 4'b0001;
        @(negedge clk);
        model_reset();
        check_all("rstmid", 1'b0);
        reset = 1'b1; hold = 4'b0001;
        clr();
        run_beat(4'b0001, 4, 4'd0, 1'b0, -1, 4'd0);
        chk("held.judge", 32'(judge), 32'd1);
        hold = 4'd0;

        // Randomized windows
        for (int n = 0; n < 300; n++) begin
            gen_window(st, close);
            run_beat(st, close, 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)),
                     ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 2) == 0) ? $urandom_range(0, close) : -1,
                     4'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
